// File: rtl/value_writer.sv
// -----------------------------------------------------------------------------
// value_writer
//
// Four-lane write-side buffer. Each lane has a small FIFO fed by a write strobe
// with full back-pressure. A round-robin drain engine moves one value per cycle
// from the FIFOs to a single shared result-memory write port. Each lane owns the
// address region selected by the top two address bits, and a per-lane write
// pointer walks through that region, wrapping when it runs off the end.
//
// Parameters
//   DATA_WIDTH  width of one lane value
//   FIFO_DEPTH  entries per lane FIFO (power of two, >= 2)
//   ADDR_WIDTH  memory address width; top 2 bits select the lane region
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   write     in   [3:0] per-lane push strobe
//   in        in   [4*DATA_WIDTH-1:0] lane values, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   full      out  [3:0] per-lane FIFO full (combinational from registered counts)
//   mem_we    out  memory write enable (registered)
//   mem_addr  out  [ADDR_WIDTH-1:0] {lane, lane_ptr} (registered)
//   mem_data  out  [DATA_WIDTH-1:0] value being written (registered)
//   overflow  out  [3:0] sticky dropped-push flags, only when VALUE_WRITER_OVF_EN
//                  is defined
//   busy      out  high while any FIFO holds data or mem_we is high
//
// Build option
//   VALUE_WRITER_OVF_EN  when defined, adds the registered sticky `overflow`
//                        port; when undefined, dropped pushes are unreported.
// -----------------------------------------------------------------------------
module value_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              write,
  input  logic [4*DATA_WIDTH-1:0] in,
  output logic [3:0]              full,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_data,
`ifdef VALUE_WRITER_OVF_EN
  output logic [3:0]              overflow,
`endif
  output logic                    busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int LW = ADDR_WIDTH - 2;

  // FIFO storage carries no reset: clearing the counts is enough to discard it.
  logic [DATA_WIDTH-1:0] fifo_q  [4][FIFO_DEPTH];

  logic [CW-1:0]         cnt_q   [4];
  logic [CW-1:0]         cnt_d   [4];
  logic [PW-1:0]         wptr_q  [4];
  logic [PW-1:0]         rptr_q  [4];
  logic [LW-1:0]         lptr_q  [4];
  logic [1:0]            rr_q;

  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_data_q;

  logic [3:0]            push;
  logic [3:0]            pop;
  logic                  gnt_vld;
  logic [1:0]            gnt_lane;
  logic [1:0]            cand;

  // Full is decoded from the start-of-cycle count, so a push to a full lane is
  // dropped even when that lane is popped in the same cycle.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      full[i] = (cnt_q[i] == CW'(FIFO_DEPTH));
    end
  end

  assign push = write & ~full;

  // Round-robin search starting just above the last granted lane. Only the
  // registered counts are consulted, so a value pushed this cycle cannot be
  // granted until the next one.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_lane = 2'd0;
    cand     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = rr_q + 2'(k);
      if (!gnt_vld && (cnt_q[cand] != '0)) begin
        gnt_vld  = 1'b1;
        gnt_lane = cand;
      end
    end
  end

  assign pop = gnt_vld ? (4'b0001 << gnt_lane) : 4'b0000;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end

  always_comb begin
    busy = mem_we_q;
    for (int i = 0; i < 4; i++) begin
      if (cnt_q[i] != '0) busy = 1'b1;
    end
  end

  // Control state and registered memory port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]  <= '0;
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        lptr_q[i] <= '0;
      end
      rr_q       <= 2'd3;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (push[i]) wptr_q[i] <= wptr_q[i] + PW'(1);
        if (pop[i])  rptr_q[i] <= rptr_q[i] + PW'(1);
      end
      mem_we_q <= gnt_vld;
      if (gnt_vld) begin
        mem_addr_q       <= {gnt_lane, lptr_q[gnt_lane]};
        mem_data_q       <= fifo_q[gnt_lane][rptr_q[gnt_lane]];
        lptr_q[gnt_lane] <= lptr_q[gnt_lane] + LW'(1);
        rr_q             <= gnt_lane;
      end
    end
  end

  // FIFO data write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) fifo_q[i][wptr_q[i]] <= in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;

`ifdef VALUE_WRITER_OVF_EN
  logic [3:0] ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 4'b0000;
    else     ovf_q <= ovf_q | (write & full);
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_value_writer.sv
// -----------------------------------------------------------------------------
// tb_value_writer
//
// Drives value_writer with directed scenarios and random push traffic. A queue
// based reference model of the four lanes predicts every memory write; the
// predictions go into a scoreboard queue that a separate monitor drains as the
// DUT presents writes.
// -----------------------------------------------------------------------------
module tb_value_writer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      write = 4'b0000;
  logic [4*DW-1:0] in_bus = '0;
  logic [3:0]      full;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data;
  logic            busy;
`ifdef VALUE_WRITER_OVF_EN
  logic [3:0]      overflow;
`endif

  value_writer #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .write   (write),
    .in      (in_bus),
    .full    (full),
    .mem_we  (mem_we),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
`ifdef VALUE_WRITER_OVF_EN
    .overflow(overflow),
`endif
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0]      mq [4][$];
  int                 lptr [4];
  int                 rr;
  bit                 mwe;
  logic [3:0]         movf;
  logic [AW+DW-1:0]   exp_q [$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      lptr[i] = 0;
    end
    rr   = 3;
    mwe  = 0;
    movf = 4'b0000;
    exp_q.delete();
  endtask

  // One clock cycle: check the visible state against the model, apply inputs,
  // advance the model by one edge, then move to just after the next edge.
  task automatic step(input logic [3:0] wr, input logic [4*DW-1:0] din);
    int         g;
    int         l;
    logic [3:0] acc;
    logic [3:0] ef;
    logic [31:0] eb;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    ef = 4'b0000;
    eb = mwe ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      ef[i] = (mq[i].size() == DEPTH);
      if (mq[i].size() != 0) eb = 1;
    end
    chk("full", full, ef);
    chk("busy", busy, eb);
`ifdef VALUE_WRITER_OVF_EN
    chk("overflow", overflow, movf);
`endif
    write  = wr;
    in_bus = din;
    g = -1;
    for (int k = 1; k <= 4; k++) begin
      l = (rr + k) % 4;
      if (g < 0 && mq[l].size() > 0) g = l;
    end
    for (int i = 0; i < 4; i++) begin
      acc[i] = wr[i] && (mq[i].size() < DEPTH);
      if (wr[i] && !acc[i]) movf[i] = 1'b1;
    end
    if (g >= 0) begin
      a = AW'(g * 256 + lptr[g]);
      d = mq[g].pop_front();
      exp_q.push_back({a, d});
      lptr[g] = (lptr[g] + 1) % 256;
      rr  = g;
      mwe = 1;
    end else begin
      mwe = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) mq[i].push_back(din[i*DW +: DW]);
    end
    @(posedge clk);
    #1;
    write = 4'b0000;
  endtask

  task automatic do_reset();
    // The only prediction allowed to be outstanding is the write from the
    // edge just passed, which the reset wipes before the monitor sees it.
    chk("sb_pending", exp_q.size(), mwe ? 1 : 0);
    rst   = 1'b1;
    write = 4'b0000;
    #1;
    chk("rst_we",   mem_we,   0);
    chk("rst_busy", busy,     0);
    chk("rst_full", full,     0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
`ifdef VALUE_WRITER_OVF_EN
    chk("rst_ovf",  overflow, 0);
`endif
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mwe || mq[0].size() != 0 || mq[1].size() != 0 ||
            mq[2].size() != 0 || mq[3].size() != 0) && n < 100) begin
      step(4'b0000, '0);
      n++;
    end
    chk("drain_bound", (n < 100) ? 1 : 0, 1);
    chk("drain_sb", exp_q.size(), 0);
    chk("drain_busy", busy, 0);
  endtask

  // Monitor: every presented write must match the oldest prediction.
  initial begin
    logic [AW+DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && mem_we) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: write addr %0h data %0h, none predicted", mem_addr, mem_data);
        end else begin
          e = exp_q.pop_front();
          chk("sb_write", {mem_addr, mem_data}, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4*DW-1:0] r;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Single-lane latency
    step(4'b0010, 32'h0000A500);
    chk("lat_we_E", mem_we, 0);
    step(4'b0000, '0);
    chk("lat_we", mem_we, 1);
    chk("lat_addr", mem_addr, 'h100);
    chk("lat_data", mem_data, 'hA5);
    step(4'b0000, '0);
    chk("lat_we_off", mem_we, 0);
    drain();

    // Round robin across all lanes
    do_reset();
    step(4'b1111, 32'h13121110);
    for (int k = 0; k < 4; k++) begin
      step(4'b0000, '0);
      chk("rr_we", mem_we, 1);
      chk("rr_addr", mem_addr, k * 256);
      chk("rr_data", mem_data, 'h10 + k);
    end
    step(4'b0000, '0);
    chk("rr_busy_end", busy, 0);
    drain();

    // Full and drop on lane 3
    do_reset();
    for (int i = 0; i < 5; i++) step(4'b1000, {8'(8'h30 + i), 24'h0});
    for (int c = 0; c < 6; c++) begin
      r = $urandom;
      step(4'b1111, r);
      if (c == 3) chk("full3_reached", full[3], 1);
    end
`ifdef VALUE_WRITER_OVF_EN
    chk("ovf3", overflow[3], 1);
`endif
    drain();

    // Lane pointer wrap on lane 0
    do_reset();
    for (int i = 0; i < 257; i++) step(4'b0001, 32'(8'((i * 7 + 3) & 8'hFF)));
    step(4'b0000, '0);
    chk("wrap_we", mem_we, 1);
    chk("wrap_addr", mem_addr, 0);
    chk("wrap_data", mem_data, (256 * 7 + 3) & 'hFF);
    drain();

    // Continuous single-lane stream on lane 2
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(4'b0100, {8'h0, 8'(8'h40 + i), 16'h0});
      chk("stream_full2", full[2], 0);
      if (i >= 1) chk("stream_addr", mem_addr, 'h200 + i - 1);
    end
    drain();

    // Reset in the middle of draining
    do_reset();
    step(4'b1111, $urandom);
    step(4'b1111, $urandom);
    step(4'b0000, '0);
    do_reset();
    step(4'b0100, 32'h00770000);
    step(4'b0000, '0);
    chk("post_rst_we", mem_we, 1);
    chk("post_rst_addr", mem_addr, 'h200);
    chk("post_rst_data", mem_data, 'h77);
    drain();

    // Random traffic: heavy load first, then sparse
    do_reset();
    for (int i = 0; i < 300; i++) step(4'($urandom_range(0, 15)), $urandom);
    for (int i = 0; i < 300; i++) step(4'($urandom_range(0, 15) & $urandom_range(0, 15)), $urandom);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
